// File: rtl/axi4_lite_seg7_ctrl.sv
// AXI4-Lite slave with CTRL/VALUE/DIG_EN/ID registers driving eight hex 7-segment digits.
// Define SEG7_ACTIVE_LOW_EN to invert every segment output for common-anode boards.
module axi4_lite_seg7_ctrl #(
   parameter int unsigned G_AXI4_LITE_ADDR_WIDTH = 32,
   parameter int unsigned G_AXI4_LITE_DATA_WIDTH = 32
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  awvalid,
   output logic                                  awready,
   input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]     awaddr,
   input  logic [2:0]                            awprot,
   input  logic                                  wvalid,
   output logic                                  wready,
   input  logic [G_AXI4_LITE_DATA_WIDTH-1:0]     wdata,
   input  logic [G_AXI4_LITE_DATA_WIDTH/8-1:0]   wstrb,
   output logic                                  bvalid,
   input  logic                                  bready,
   output logic [1:0]                            bresp,
   input  logic                                  arvalid,
   output logic                                  arready,
   input  logic [G_AXI4_LITE_ADDR_WIDTH-1:0]     araddr,
   input  logic [2:0]                            arprot,
   output logic                                  rvalid,
   input  logic                                  rready,
   output logic [G_AXI4_LITE_DATA_WIDTH-1:0]     rdata,
   output logic [1:0]                            rresp,
   output logic [6:0]                            o_seg0,
   output logic [6:0]                            o_seg1,
   output logic [6:0]                            o_seg2,
   output logic [6:0]                            o_seg3,
   output logic [6:0]                            o_seg4,
   output logic [6:0]                            o_seg5,
   output logic [6:0]                            o_seg6,
   output logic [6:0]                            o_seg7
);

   localparam int unsigned AW = G_AXI4_LITE_ADDR_WIDTH;
   localparam int unsigned DW = G_AXI4_LITE_DATA_WIDTH;
   localparam int unsigned SW = DW / 8;
   localparam int unsigned WA = AW - 2;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [31:0] ID_VALUE    = 32'h75E6_0001;
`ifdef SEG7_ACTIVE_LOW_EN
   localparam logic [6:0]  SEG_XOR = 7'h7F;
`else
   localparam logic [6:0]  SEG_XOR = 7'h00;
`endif

   logic          r_aw_valid;
   logic [WA-1:0] r_aw_addr;
   logic          r_w_valid;
   logic [DW-1:0] r_w_data;
   logic [SW-1:0] r_w_strb;
   logic          r_bvalid;
   logic [1:0]    r_bresp;
   logic          r_rvalid;
   logic [DW-1:0] r_rdata;
   logic [1:0]    r_rresp;
   logic          r_ctrl;
   logic [31:0]   r_value;
   logic [7:0]    r_dig_en;
   logic [6:0]    w_seg [8];
   logic          w_unused;

   // word address (byte offset stripped): mapped only when everything above bit 3 is zero
   function automatic logic is_mapped(input logic [WA-1:0] a);
      return (a >> 2) == '0;
   endfunction

   function automatic logic [31:0] rd_reg(input logic [1:0] idx);
      case (idx)
         2'd0:    return {31'd0, r_ctrl};
         2'd1:    return r_value;
         2'd2:    return {24'd0, r_dig_en};
         default: return ID_VALUE;
      endcase
   endfunction

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   assign awready = rst_n & ~r_aw_valid & ~r_bvalid;
   assign wready  = rst_n & ~r_w_valid & ~r_bvalid;
   assign arready = rst_n & ~r_rvalid;
   assign bvalid  = r_bvalid;
   assign bresp   = r_bresp;
   assign rvalid  = r_rvalid;
   assign rdata   = r_rdata;
   assign rresp   = r_rresp;
   assign w_unused = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

   // write path: independent AW/W latches, commit on the edge after both are held
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_aw_valid <= 1'b0;
         r_aw_addr  <= '0;
         r_w_valid  <= 1'b0;
         r_w_data   <= '0;
         r_w_strb   <= '0;
         r_bvalid   <= 1'b0;
         r_bresp    <= RESP_OKAY;
         r_ctrl     <= 1'b0;
         r_value    <= 32'h0;
         r_dig_en   <= 8'hFF;
      end else begin
         if (awvalid && awready) begin
            r_aw_valid <= 1'b1;
            r_aw_addr  <= awaddr[AW-1:2];
         end
         if (wvalid && wready) begin
            r_w_valid <= 1'b1;
            r_w_data  <= wdata;
            r_w_strb  <= wstrb;
         end
         if (r_aw_valid && r_w_valid) begin
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_bvalid   <= 1'b1;
            r_bresp    <= is_mapped(r_aw_addr) ? RESP_OKAY : RESP_SLVERR;
            if (is_mapped(r_aw_addr)) begin
               case (r_aw_addr[1:0])
                  2'd0: if (r_w_strb[0]) r_ctrl <= r_w_data[0];
                  2'd1: for (int b = 0; b < SW; b++)
                           if (r_w_strb[b]) r_value[8*b +: 8] <= r_w_data[8*b +: 8];
                  2'd2: if (r_w_strb[0]) r_dig_en <= r_w_data[7:0];
                  default: ;
               endcase
            end
         end else if (r_bvalid && bready) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // read path: capture on AR handshake, hold until rready
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
      end else if (arvalid && arready) begin
         r_rvalid <= 1'b1;
         if (is_mapped(araddr[AW-1:2])) begin
            r_rdata <= rd_reg(araddr[3:2]);
            r_rresp <= RESP_OKAY;
         end else begin
            r_rdata <= '0;
            r_rresp <= RESP_SLVERR;
         end
      end else if (r_rvalid && rready) begin
         r_rvalid <= 1'b0;
      end
   end

   for (genvar g = 0; g < 8; g++) begin : g_dig
      assign w_seg[g] = ((r_ctrl && r_dig_en[g]) ? hex7(r_value[4*g +: 4]) : 7'h00) ^ SEG_XOR;
   end

   assign o_seg0 = w_seg[0];
   assign o_seg1 = w_seg[1];
   assign o_seg2 = w_seg[2];
   assign o_seg3 = w_seg[3];
   assign o_seg4 = w_seg[4];
   assign o_seg5 = w_seg[5];
   assign o_seg6 = w_seg[6];
   assign o_seg7 = w_seg[7];

endmodule

// File: tb/tb_axi4_lite_seg7_ctrl.sv
// Directed bench for axi4_lite_seg7_ctrl: register map, strobes, errors, segment decode, handshake ordering.
module tb_axi4_lite_seg7_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
   logic [3:0]  wstrb = '0;
   logic [2:0]  awprot = '0, arprot = '0;
   logic [1:0]  bresp, rresp;
   logic [6:0]  o_seg0, o_seg1, o_seg2, o_seg3, o_seg4, o_seg5, o_seg6, o_seg7;

   int n_total = 0;
   int n_bad   = 0;

`ifdef SEG7_ACTIVE_LOW_EN
   localparam logic [6:0] SEG_INV = 7'h7F;
`else
   localparam logic [6:0] SEG_INV = 7'h00;
`endif

   axi4_lite_seg7_ctrl #(.G_AXI4_LITE_ADDR_WIDTH(32), .G_AXI4_LITE_DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .o_seg0(o_seg0), .o_seg1(o_seg1), .o_seg2(o_seg2), .o_seg3(o_seg3),
      .o_seg4(o_seg4), .o_seg5(o_seg5), .o_seg6(o_seg6), .o_seg7(o_seg7)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input int i);
      case (i)
         0: return o_seg0;  1: return o_seg1;  2: return o_seg2;  3: return o_seg3;
         4: return o_seg4;  5: return o_seg5;  6: return o_seg6;  default: return o_seg7;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_segs(input string tag, input logic [6:0] exp [8]);
      for (int i = 0; i < 8; i++)
         check($sformatf("%s_seg%0d", tag, i), 32'(seg_of(i)), 32'(exp[i] ^ SEG_INV));
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      logic aw_hit, w_hit, aw_done, w_done;
      int n;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1;
      aw_done = 1'b0; w_done = 1'b0; n = 0;
      while (!(aw_done && w_done) && n < 20) begin
         aw_hit = awvalid & awready;
         w_hit  = wvalid & wready;
         tick();
         if (aw_hit) begin awvalid = 1'b0; aw_done = 1'b1; end
         if (w_hit)  begin wvalid  = 1'b0; w_done  = 1'b1; end
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b1; n = 0;
      while (!bvalid && n < 20) begin tick(); n++; end
      check($sformatf("wr_bvalid_%h", a), 32'(bvalid), 32'd1);
      resp = bresp;
      tick();
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      araddr = a; arvalid = 1'b1; n = 0;
      while (!arready && n < 20) begin tick(); n++; end
      tick();
      arvalid = 1'b0;
      rready = 1'b1; n = 0;
      while (!rvalid && n < 20) begin tick(); n++; end
      check($sformatf("rd_rvalid_%h", a), 32'(rvalid), 32'd1);
      d = rdata; resp = rresp;
      tick();
      rready = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      logic [6:0]  exp_seg [8];

      // reset: ready outputs low while asserted
      repeat (3) tick();
      check("rst_awready", 32'(awready), 32'd0);
      check("rst_arready", 32'(arready), 32'd0);
      check("rst_bvalid",  32'(bvalid),  32'd0);
      check("rst_rdata",   rdata,        32'd0);
      rst_n = 1'b1;
      tick();
      check("idle_awready", 32'(awready), 32'd1);

      axi_read(32'h0, d, r); check("rst_ctrl", d, 32'h0);        check("rst_ctrl_rresp", 32'(r), 32'd0);
      axi_read(32'h4, d, r); check("rst_value", d, 32'h0);       check("rst_value_rresp", 32'(r), 32'd0);
      axi_read(32'h8, d, r); check("rst_digen", d, 32'hFF);      check("rst_digen_rresp", 32'(r), 32'd0);
      axi_read(32'hC, d, r); check("rst_id", d, 32'h75E6_0001);  check("rst_id_rresp", 32'(r), 32'd0);
      exp_seg = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
      check_segs("rst", exp_seg);

      // full word then enable
      axi_write(32'h4, 32'h8765_4321, 4'hF, r); check("wr_value_bresp", 32'(r), 32'd0);
      axi_write(32'h0, 32'h1, 4'hF, r);         check("wr_ctrl_bresp", 32'(r), 32'd0);
      exp_seg = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F};
      check_segs("v1", exp_seg);
      axi_read(32'h4, d, r); check("rb_value1", d, 32'h8765_4321);

      // partial strobe: only low two bytes land
      axi_write(32'h4, 32'hFEDC_BA98, 4'h3, r);
      axi_read(32'h4, d, r); check("rb_value_strb", d, 32'h8765_BA98);
      exp_seg = '{7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h6D, 7'h7D, 7'h07, 7'h7F};
      check_segs("v2", exp_seg);

      // zero strobe changes nothing
      axi_write(32'h4, 32'h0, 4'h0, r);
      axi_read(32'h4, d, r); check("rb_value_strb0", d, 32'h8765_BA98);

      axi_write(32'h8, 32'h0F, 4'hF, r);
      exp_seg = '{7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h00, 7'h00, 7'h00, 7'h00};
      check_segs("digen", exp_seg);
      axi_write(32'h0, 32'h0, 4'hF, r);
      exp_seg = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
      check_segs("off", exp_seg);

      // unmapped and read-only accesses
      axi_write(32'h10, 32'hFFFF_FFFF, 4'hF, r); check("unm_bresp", 32'(r), 32'd2);
      axi_read(32'h10, d, r); check("unm_rdata", d, 32'h0); check("unm_rresp", 32'(r), 32'd2);
      axi_read(32'h0, d, r);  check("unm_ctrl", d, 32'h0);
      axi_read(32'h4, d, r);  check("unm_value", d, 32'h8765_BA98);
      axi_read(32'h8, d, r);  check("unm_digen", d, 32'h0F);
      axi_write(32'hC, 32'h1234_5678, 4'hF, r); check("id_bresp", 32'(r), 32'd0);
      axi_read(32'hC, d, r);  check("id_ro", d, 32'h75E6_0001);

      // W two cycles ahead of AW, bready held low for three cycles
      wdata = 32'h1122_3344; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      check("ooo_wready_held", 32'(wready), 32'd0);
      tick();
      awaddr = 32'h4; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      check("ooo_bvalid_early", 32'(bvalid), 32'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("ooo_bvalid_hold%0d", i), 32'(bvalid), 32'd1);
         check($sformatf("ooo_bresp_hold%0d", i), 32'(bresp), 32'd0);
         check($sformatf("ooo_awready_hold%0d", i), 32'(awready), 32'd0);
         check($sformatf("ooo_wready_hold%0d", i), 32'(wready), 32'd0);
         tick();
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      check("ooo_bvalid_clear", 32'(bvalid), 32'd0);
      tick();
      check("ooo_bvalid_single", 32'(bvalid), 32'd0);
      axi_read(32'h4, d, r); check("ooo_value", d, 32'h1122_3344);

      // reset with a half-written transaction pending
      awaddr = 32'h0; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      repeat (3) tick();
      check("rstmid_bvalid", 32'(bvalid), 32'd0);
      axi_read(32'h0, d, r); check("rstmid_ctrl", d, 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
